// File: rtl/booth_seq_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : booth_seq_multiplier                                       |
// | Description : Iterative radix-2 Booth multiplier. One shared N-bit        |
// |               adder/subtractor performs one add/sub-and-shift step per    |
// |               clock (N = WIDTH+1). Signed or unsigned mode is selected    |
// |               per operation; result is held until the next accepted op.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module booth_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   is_signed,
  input  logic [WIDTH-1:0]       multiplicand,
  input  logic [WIDTH-1:0]       multiplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product
);

  // One extra bit lets unsigned operands be treated as non-negative signed
  // values, so a single signed Booth datapath covers both modes.
  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        acc_q, acc_d;
  logic [N-1:0]        mq_q, mq_d;        // multiplier register Q
  logic                qm1_q, qm1_d;      // Booth q-1 bit
  logic [N-1:0]        m_q, m_d;          // extended multiplicand
  logic [CW-1:0]       count_q, count_d;
  logic [2*WIDTH-1:0]  product_q, product_d;

  logic [N-1:0]        ext_m;
  logic [N-1:0]        ext_q;
  logic                do_add;
  logic                do_sub;
  logic [N-1:0]        addend;
  logic [N-1:0]        sum;
  logic [N-1:0]        step_acc;
  logic [N-1:0]        step_q;
  logic                step_qm1;

  // Operand extension to N bits according to the requested mode
  always_comb begin
    ext_m = is_signed ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
    ext_q = is_signed ? {multiplier[WIDTH-1], multiplier}     : {1'b0, multiplier};
  end

  // One Booth step: decode {Q[0],q-1}, shared add/sub, then arithmetic shift
  always_comb begin
    do_sub   = mq_q[0] & ~qm1_q;
    do_add   = ~mq_q[0] & qm1_q;
    addend   = do_sub ? ~m_q : (do_add ? m_q : '0);
    // Subtraction is ~M plus a carry-in of one; the carry out is discarded.
    sum      = acc_q + addend + {{(N-1){1'b0}}, do_sub};
    step_acc = {sum[N-1], sum[N-1:1]};
    step_q   = {sum[0], mq_q[N-1:1]};
    step_qm1 = mq_q[0];
  end

  // Next-state and register-next logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start just like IDLE, giving back-to-back ops.
        if (start) begin
          m_d     = ext_m;
          mq_d    = ext_q;
          acc_d   = '0;
          qm1_d   = 1'b0;
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = step_acc;
        mq_d    = step_q;
        qm1_d   = step_qm1;
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          // The top two bits of {acc,Q} are pure sign extension here.
          product_d = {step_acc[N-3:0], step_q};
          state_d   = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mq_q      <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Status outputs decode straight from the state so reset clears them at once
  always_comb begin
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    product = product_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_booth_seq_multiplier                                    |
// | Description : Directed and swept self-checking bench for the sequential   |
// |               Booth multiplier at WIDTH=8 and WIDTH=16.                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_booth_seq_multiplier;

  logic clk;
  logic rst;

  logic        start8, is8;
  logic [7:0]  m8, q8;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        start16, is16;
  logic [15:0] m16, q16;
  logic        busy16, done16;
  logic [31:0] prod16;

  int n_checks;
  int n_fail;

  booth_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .start        (start8),
    .is_signed    (is8),
    .multiplicand (m8),
    .multiplier   (q8),
    .busy         (busy8),
    .done         (done8),
    .product      (prod8)
  );

  booth_seq_multiplier #(.WIDTH(16)) dut16 (
    .clk          (clk),
    .rst          (rst),
    .start        (start16),
    .is_signed    (is16),
    .multiplicand (m16),
    .multiplier   (q16),
    .busy         (busy16),
    .done         (done16),
    .product      (prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one 8-bit op; lat counts edges after the start edge until done is seen
  task automatic do_op8(input logic s, input logic [7:0] m, input logic [7:0] q,
                        output int lat, output logic [15:0] p);
    start8 = 1'b1; is8 = s; m8 = m; q8 = q;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    p = 'x;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (done8) begin
        p = prod8;
        break;
      end
    end
  endtask

  task automatic do_op16(input logic s, input logic [15:0] m, input logic [15:0] q,
                         output int lat, output logic [31:0] p);
    start16 = 1'b1; is16 = s; m16 = m; q16 = q;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    p = 'x;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done16) begin
        p = prod16;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 0; is8 = 0; m8 = 0; q8 = 0;
    start16 = 0; is16 = 0; m16 = 0; q16 = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy8, done8, prod8} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b product=%h, required 0/0/0000", busy8, done8, prod8);
    end
    n_checks++;
    if ({busy16, done16, prod16} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset16: busy=%b done=%b product=%h, required 0/0/00000000", busy16, done16, prod16);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_signed_extremes();
    int lat;
    logic [15:0] p;
    do_op8(1'b1, 8'h80, 8'h80, lat, p);
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL latency_min_min: got %0d edges, required 9", lat);
    end
    n_checks++;
    if (p !== 16'h4000) begin
      n_fail++;
      $display("FAIL signed_min_min: got %h, required 4000", p);
    end
    do_op8(1'b1, 8'd127, 8'hFF, lat, p);
    n_checks++;
    if (p !== 16'hFF81) begin
      n_fail++;
      $display("FAIL signed_127_x_m1: got %h, required ff81", p);
    end
  endtask

  task automatic test_unsigned();
    int lat;
    logic [15:0] p;
    do_op8(1'b0, 8'hFF, 8'hFF, lat, p);
    n_checks++;
    if (p !== 16'hFE01) begin
      n_fail++;
      $display("FAIL unsigned_255x255: got %h, required fe01", p);
    end
    do_op8(1'b1, 8'hFF, 8'hFF, lat, p);
    n_checks++;
    if (p !== 16'h0001) begin
      n_fail++;
      $display("FAIL signed_m1xm1: got %h, required 0001", p);
    end
    do_op8(1'b0, 8'd0, 8'd0, lat, p);
    n_checks++;
    if (lat !== 9 || p !== 16'h0000) begin
      n_fail++;
      $display("FAIL zero_operands: lat=%0d product=%h, required 9/0000", lat, p);
    end
  endtask

  task automatic test_start_ignored();
    int c;
    int n_done;
    int first_done;
    logic saw_busy;
    start8 = 1'b1; is8 = 1'b1; m8 = 8'd5; q8 = 8'd7;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_done = 0; first_done = -1; saw_busy = 1'b0;
    for (c = 1; c <= 25; c++) begin
      if (c == 3 || c == 6) begin
        start8 = 1'b1; m8 = 8'd100; q8 = 8'd100; is8 = 1'b0;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      if (c == 1) saw_busy = busy8;
      if (done8) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
    end
    start8 = 1'b0;
    n_checks++;
    if (saw_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_run: got %b, required 1", saw_busy);
    end
    n_checks++;
    if (n_done !== 1 || first_done !== 9) begin
      n_fail++;
      $display("FAIL ignored_start_done: pulses=%0d first=%0d, required 1/9", n_done, first_done);
    end
    n_checks++;
    if (prod8 !== 16'd35) begin
      n_fail++;
      $display("FAIL ignored_start_product: got %h, required 0023", prod8);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int d1;
    int d2;
    logic [15:0] p1;
    logic [15:0] p2;
    d1 = -1; d2 = -1; p1 = 'x; p2 = 'x;
    start8 = 1'b1; is8 = 1'b1; m8 = 8'd3; q8 = 8'hFC;
    @(posedge clk); #1;
    for (c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (d1 >= 0 && c == d1 + 1) start8 = 1'b0;
      if (done8) begin
        if (d1 < 0) begin
          d1 = c; p1 = prod8;
          is8 = 1'b0; m8 = 8'd200; q8 = 8'd3;
        end else if (d2 < 0) begin
          d2 = c; p2 = prod8;
        end
      end
    end
    start8 = 1'b0;
    n_checks++;
    if (p1 !== 16'hFFF4) begin
      n_fail++;
      $display("FAIL b2b_first_product: got %h, required fff4", p1);
    end
    n_checks++;
    if (p2 !== 16'h0258) begin
      n_fail++;
      $display("FAIL b2b_second_product: got %h, required 0258", p2);
    end
    n_checks++;
    if (d1 !== 9 || d2 !== 19) begin
      n_fail++;
      $display("FAIL b2b_spacing: done at %0d and %0d, required 9 and 19", d1, d2);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [15:0] p;
    start8 = 1'b1; is8 = 1'b1; m8 = 8'd9; q8 = 8'd9;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy8, done8, prod8} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b done=%b product=%h, required 0/0/0000", busy8, done8, prod8);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: done=%b, required 0", done8);
    end
    do_op8(1'b1, 8'd12, 8'hF5, lat, p);
    n_checks++;
    if (lat !== 9 || p !== 16'hFF7C) begin
      n_fail++;
      $display("FAIL after_reset_op: lat=%0d product=%h, required 9/ff7c", lat, p);
    end
  endtask

  task automatic test_sweep16();
    logic [15:0] corners [5];
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] p;
    logic [31:0] exp;
    longint      la;
    longint      lb;
    int          lat;
    corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'hFFFF;
    corners[3] = 16'h8000; corners[4] = 16'h7FFF;
    for (int k = 0; k < 2100; k++) begin
      if (k < 50) begin
        s = k[0];
        a = corners[(k / 2) % 5];
        b = corners[(k / 10) % 5];
      end else begin
        s = 1'($urandom_range(0, 1));
        a = 16'($urandom);
        b = 16'($urandom);
      end
      if (s) begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
      end else begin
        la = longint'(a);
        lb = longint'(b);
      end
      exp = 32'(la * lb);
      do_op16(s, a, b, lat, p);
      n_checks++;
      if (lat !== 17) begin
        n_fail++;
        $display("FAIL sweep16_latency: op %0d got %0d edges, required 17", k, lat);
      end
      n_checks++;
      if (p !== exp) begin
        n_fail++;
        $display("FAIL sweep16_product: op %0d s=%b %h*%h got %h, required %h", k, s, a, b, p, exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_signed_extremes();
    test_unsigned();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
